sum_requantizer: RTL and testbench
==================================

Name: sum_requantizer

Overview:
- Converts the widened signed sums produced by the neuron adder tree back to the addend width, so results can feed the next layer's adders and multipliers.
- Conversion is a rounding arithmetic right shift followed by saturation.
- Two-stage pipeline with valid/ready handshaking on both sides, plus a sticky saturation counter for overflow monitoring.

Parameters:
- ADDEND_WIDTH, 16, output (narrow) signed width.
- SUM_WIDTH, ADDEND_WIDTH+1, input (wide) signed width; must be >= ADDEND_WIDTH.
- SHIFT, 0, arithmetic right-shift amount applied before saturation; 0 <= SHIFT < SUM_WIDTH.
- SAT_COUNT_WIDTH, 8, width of the saturation event counter.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous active-high reset.
- sum_in  input  SUM_WIDTH  signed wide sum.
- sum_valid_in  input  1  sum_in is valid.
- sum_ready_out  output  1  block accepts sum_in this cycle.
- data_out  output  ADDEND_WIDTH  signed requantized result.
- data_valid_out  output  1  data_out is valid.
- data_ready_in  input  1  downstream accepts data_out.
- sat_flag_out  output  1  data_out was saturated; qualified by data_valid_out.
- sat_count_out  output  SAT_COUNT_WIDTH  saturating count of saturated results delivered.
- sat_count_clear_in  input  1  synchronous clear of sat_count_out.

Behaviour:
- Reset:
  - data_out = 0, data_valid_out = 0, sat_flag_out = 0, sat_count_out = 0.
  - Both stage-valid bits are cleared, so in-flight data is discarded.
  - sum_ready_out = 1 in the cycle after reset deasserts.
- Reset mid-operation drops all pending results; no partial output appears.
- Pipeline advance: adv = !data_valid_out || data_ready_in.
  - sum_ready_out = adv, combinational.
  - Input accept = sum_valid_in && sum_ready_out.
- Stage 1, on adv:
  - Register sum_in and the valid bit (the valid bit takes the accept value).
- Stage 2, on adv:
  - Computes from stage-1 data; registers data_out, sat_flag_out, and data_valid_out.
  - data_valid_out takes the stage-1 valid bit.
- Latency: 2 cycles from accept to data_valid_out when unstalled; throughput 1 per cycle.
- Stall (data_valid_out && !data_ready_in):
  - All stage registers hold and sum_ready_out = 0.
  - data_out and sat_flag_out stay stable until the handshake completes.
- Arithmetic, computed in SUM_WIDTH+1 bits signed to avoid rounding overflow:
  - If SHIFT > 0: r = (sum + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - If SHIFT = 0: r = sum.
- Saturation:
  - r > 2^(ADDEND_WIDTH-1)-1 -> output max positive, sat flag = 1.
  - r < -2^(ADDEND_WIDTH-1) -> output min negative, sat flag = 1.
  - Otherwise output = r truncated to ADDEND_WIDTH, sat flag = 0.
- sat_count_out:
  - Increments once per delivered handshake (data_valid_out && data_ready_in) with sat_flag_out = 1.
  - Holds at 2^SAT_COUNT_WIDTH-1; no wrap.
  - Clear has priority over increment in the same cycle; the counter reads 0 the next cycle.
- A bubble (no input valid) propagates as valid = 0 and does not disturb the held data of neighbouring stages beyond normal advance.
- Simultaneous output handshake and new input accept in the same cycle is legal; full throughput is maintained.

Test Plan:
- ADDEND_WIDTH=16, SUM_WIDTH=17, SHIFT=1, ready held high; send 5, -5, -65536 back-to-back -> outputs 3, -2, -32768 on consecutive cycles starting 2 cycles after first accept; sat_flag_out = 0 for all.
- Same config; send 65535 -> data_out = 32767, sat_flag_out = 1, sat_count_out = 1 after handshake.
- SHIFT=0; send 40000 then -40000 -> 32767 then -32768, both flagged, sat_count_out = 2; send 1234 -> 1234, unflagged, count unchanged.
- Backpressure: data_ready_in = 0 for 5 cycles while streaming 1, 2, 3 -> sum_ready_out drops, data_out holds 1 stable; on release, 1, 2, 3 emerge in order with none lost or duplicated.
- SAT_COUNT_WIDTH=2; deliver 5 saturating results -> count sticks at 3; assert sat_count_clear_in in the same cycle as a saturating handshake -> count = 0.
- Assert rst_in while two values are in flight -> data_valid_out = 0 the next cycle, the values never appear, sat_count_out = 0, and sum_ready_out = 1 after reset deasserts.

Source files
------------

// File: rtl/sum_requantizer.sv
// sum_requantizer: narrows wide signed adder-tree sums back to the addend width.
// Stage 1 registers the incoming sum; stage 2 applies a rounding arithmetic
// right shift (round half toward +inf) followed by saturation. A sticky,
// non-wrapping counter tallies saturated results delivered downstream.
module sum_requantizer #(
    parameter int ADDEND_WIDTH    = 16,
    parameter int SUM_WIDTH       = ADDEND_WIDTH + 1,
    parameter int SHIFT           = 0,
    parameter int SAT_COUNT_WIDTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [SUM_WIDTH-1:0]       sum_in,
    input  logic                       sum_valid_in,
    output logic                       sum_ready_out,
    output logic [ADDEND_WIDTH-1:0]    data_out,
    output logic                       data_valid_out,
    input  logic                       data_ready_in,
    output logic                       sat_flag_out,
    output logic [SAT_COUNT_WIDTH-1:0] sat_count_out,
    input  logic                       sat_count_clear_in
);

    // One guard bit above the input width keeps the rounding add from overflowing.
    localparam int XW      = SUM_WIDTH + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [XW-1:0] RND   = (SHIFT > 0) ? (XW'(1) << RND_POS) : '0;
    localparam logic signed [XW-1:0] MAX_V = {{(XW - ADDEND_WIDTH + 1){1'b0}},
                                              {(ADDEND_WIDTH - 1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_V = ~MAX_V;

    logic                       w_adv;
    logic signed [XW-1:0]       w_ext;
    logic signed [XW-1:0]       w_rnd;
    logic [ADDEND_WIDTH-1:0]    w_res;
    logic                       w_sat;
    logic                       w_deliver;

    logic [SUM_WIDTH-1:0]       r_s1_sum;
    logic                       r_s1_valid;
    logic [ADDEND_WIDTH-1:0]    r_data;
    logic                       r_valid;
    logic                       r_sat;
    logic [SAT_COUNT_WIDTH-1:0] r_cnt;

    assign w_adv          = !r_valid || data_ready_in;
    assign w_deliver      = r_valid && data_ready_in;
    assign sum_ready_out  = w_adv;
    assign data_out       = r_data;
    assign data_valid_out = r_valid;
    assign sat_flag_out   = r_sat;
    assign sat_count_out  = r_cnt;

    // Round, shift and saturate the stage-1 sum.
    always_comb begin
        w_ext = {r_s1_sum[SUM_WIDTH-1], r_s1_sum};
        if (SHIFT > 0) begin
            w_rnd = (w_ext + RND) >>> SHIFT;
        end else begin
            w_rnd = w_ext;
        end
        w_sat = 1'b0;
        w_res = w_rnd[ADDEND_WIDTH-1:0];
        if (w_rnd > MAX_V) begin
            w_res = MAX_V[ADDEND_WIDTH-1:0];
            w_sat = 1'b1;
        end else if (w_rnd < MIN_V) begin
            w_res = MIN_V[ADDEND_WIDTH-1:0];
            w_sat = 1'b1;
        end
    end

    // Stage 1: capture the input sum and its accept bit whenever the pipe advances.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_sum   <= '0;
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_sum   <= sum_in;
            r_s1_valid <= sum_valid_in;
        end
    end

    // Stage 2: register the requantized result; holds while downstream stalls.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_data  <= '0;
            r_sat   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_data  <= w_res;
            r_sat   <= w_sat;
            r_valid <= r_s1_valid;
        end
    end

    // Saturation event counter: clear wins over increment, sticks at all-ones.
    always_ff @(posedge clk_in) begin
        if (rst_in || sat_count_clear_in) begin
            r_cnt <= '0;
        end else if (w_deliver && r_sat && (r_cnt != '1)) begin
            r_cnt <= r_cnt + SAT_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sum_requantizer.sv
// Bench for sum_requantizer: two instances (SHIFT=1 with a 2-bit counter and
// SHIFT=0 with an 8-bit counter) share the same stimulus and handshakes.
module tb_sum_requantizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst       = 1'b1;
    logic               sum_valid = 1'b0;
    logic               rdy       = 1'b1;
    logic               clr       = 1'b0;
    logic signed [16:0] sum_in    = '0;

    logic               sr_a, sr_b, dv_a, dv_b, fl_a, fl_b;
    logic signed [15:0] d_a, d_b;
    logic [1:0]         cnt_a;
    logic [7:0]         cnt_b;

    int     checks = 0;
    int     errors = 0;
    longint stim_q[$];
    longint sb[$];
    bit     acc_seen = 1'b0;
    int     gap_pct  = 0;
    int     mcnt_a   = 0;
    int     mcnt_b   = 0;

    sum_requantizer #(.ADDEND_WIDTH(16), .SUM_WIDTH(17), .SHIFT(1), .SAT_COUNT_WIDTH(2)) u_dut_a (
        .clk_in(clk), .rst_in(rst), .sum_in(sum_in), .sum_valid_in(sum_valid),
        .sum_ready_out(sr_a), .data_out(d_a), .data_valid_out(dv_a), .data_ready_in(rdy),
        .sat_flag_out(fl_a), .sat_count_out(cnt_a), .sat_count_clear_in(clr)
    );

    sum_requantizer #(.ADDEND_WIDTH(16), .SUM_WIDTH(17), .SHIFT(0), .SAT_COUNT_WIDTH(8)) u_dut_b (
        .clk_in(clk), .rst_in(rst), .sum_in(sum_in), .sum_valid_in(sum_valid),
        .sum_ready_out(sr_b), .data_out(d_b), .data_valid_out(dv_b), .data_ready_in(rdy),
        .sat_flag_out(fl_b), .sat_count_out(cnt_b), .sat_count_clear_in(clr)
    );

    // Floor division for positive divisors.
    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    // Exact value of (s + half) / 2^sh rounded down, before clamping.
    function automatic longint raw_val(input longint s, input int sh);
        if (sh > 0) return fdiv(s + (longint'(1) << (sh - 1)), longint'(1) << sh);
        return s;
    endfunction

    function automatic longint model_val(input longint s, input int sh);
        longint r;
        r = raw_val(s, sh);
        if (r > 32767)  return 32767;
        if (r < -32768) return -32768;
        return r;
    endfunction

    function automatic longint model_sat(input longint s, input int sh);
        longint r;
        r = raw_val(s, sh);
        return (r > 32767 || r < -32768) ? 1 : 0;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ntick();
        @(negedge clk);
    endtask

    task automatic wait_dv(output int w);
        w = 0;
        do begin
            ntick();
            w++;
        end while (!dv_a && w < 20);
        check("wait_valid_timeout", dv_a, 1);
    endtask

    function automatic longint rand_sum();
        logic signed [16:0] t;
        t = 17'($urandom);
        case ($urandom_range(7))
            0: return 65535;
            1: return -65536;
            2: return 65534 - longint'($urandom_range(1));
            3: return -65535 + longint'($urandom_range(1));
            4: return 32767 + longint'($urandom_range(1));
            5: return -32768 - longint'($urandom_range(1));
            6: return longint'($urandom_range(200)) - 100;
            default: return t;
        endcase
    endfunction

    // Producer: presents queued sums, holding each until accepted.
    initial begin
        forever begin
            tick();
            if (rst) begin
                sum_valid = 1'b0;
            end else if (!sum_valid || acc_seen) begin
                if (stim_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                    sum_in    = 17'(stim_q.pop_front());
                    sum_valid = 1'b1;
                end else begin
                    sum_in    = 17'($urandom);
                    sum_valid = 1'b0;
                end
            end
        end
    end

    // Compare process: scoreboard of accepted sums against delivered outputs.
    always @(negedge clk) begin
        longint e;
        bit     hs;
        if (rst) begin
            sb.delete();
            mcnt_a   = 0;
            mcnt_b   = 0;
            acc_seen = 1'b0;
        end else begin
            e  = 0;
            check("ready_a", sr_a, (!dv_a || rdy) ? 1 : 0);
            check("ready_b", sr_b, (!dv_b || rdy) ? 1 : 0);
            check("valid_b", dv_b, dv_a);
            check("count_a", cnt_a, mcnt_a);
            check("count_b", cnt_b, mcnt_b);
            if (dv_a) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid got=1 expected=0 at t=%0t", $time);
                end else begin
                    e = sb[0];
                    check("data_a", d_a, model_val(e, 1));
                    check("flag_a", fl_a, model_sat(e, 1));
                    check("data_b", d_b, model_val(e, 0));
                    check("flag_b", fl_b, model_sat(e, 0));
                end
            end
            hs = dv_a && rdy && (sb.size() > 0);
            if (clr) begin
                mcnt_a = 0;
                mcnt_b = 0;
            end else if (hs) begin
                if (model_sat(e, 1) == 1 && mcnt_a < 3)   mcnt_a++;
                if (model_sat(e, 0) == 1 && mcnt_b < 255) mcnt_b++;
            end
            if (hs) void'(sb.pop_front());
            acc_seen = sum_valid && sr_a;
            if (acc_seen) sb.push_back(longint'(sum_in));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int got;

        check("model_pos_round", model_val(5, 1), 3);
        check("model_neg_round", model_val(-5, 1), -2);
        check("model_sat_pos", model_val(65535, 1), 32767);
        check("model_sat_neg0", model_val(-40000, 0), -32768);

        repeat (3) @(posedge clk);
        ntick();
        check("rst_valid", dv_a, 0);
        check("rst_data", d_a, 0);
        check("rst_flag", fl_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_valid_b", dv_b, 0);
        tick();
        rst = 1'b0;
        ntick();
        check("ready_after_rst", sr_a, 1);

        // Back-to-back rounding, latency 2 from accept.
        stim_q.push_back(5);
        stim_q.push_back(-5);
        stim_q.push_back(-65536);
        wait_dv(w);
        check("latency", w, 3);
        check("t1_a0", d_a, 3);
        check("t1_b0", d_b, 5);
        check("t1_fa0", fl_a, 0);
        ntick();
        check("t1_v1", dv_a, 1);
        check("t1_a1", d_a, -2);
        ntick();
        check("t1_v2", dv_a, 1);
        check("t1_a2", d_a, -32768);
        check("t1_fa2", fl_a, 0);
        check("t1_fb2", fl_b, 1);
        repeat (3) ntick();

        // Positive saturation with shift.
        stim_q.push_back(65535);
        wait_dv(w);
        check("t2_a", d_a, 32767);
        check("t2_fa", fl_a, 1);
        ntick();
        check("t2_cnt_a", cnt_a, 1);

        // No-shift saturation both ways, then in-range.
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        ntick();
        stim_q.push_back(40000);
        stim_q.push_back(-40000);
        wait_dv(w);
        check("t3_b0", d_b, 32767);
        check("t3_fb0", fl_b, 1);
        check("t3_a0", d_a, 20000);
        ntick();
        check("t3_b1", d_b, -32768);
        check("t3_fb1", fl_b, 1);
        check("t3_a1", d_a, -20000);
        ntick();
        check("t3_cnt_b", cnt_b, 2);
        stim_q.push_back(1234);
        wait_dv(w);
        check("t3_b2", d_b, 1234);
        check("t3_fb2", fl_b, 0);
        check("t3_a2", d_a, 617);
        ntick();
        check("t3_cnt_b_hold", cnt_b, 2);

        // Backpressure: output holds, nothing lost or duplicated on release.
        tick(); rdy = 1'b0;
        ntick();
        stim_q.push_back(1);
        stim_q.push_back(2);
        stim_q.push_back(3);
        wait_dv(w);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_low", sr_a, 0);
            check("bp_hold_b", d_b, 1);
            check("bp_hold_a", d_a, 1);
            ntick();
        end
        tick(); rdy = 1'b1;
        got = 0;
        for (int i = 0; i < 12 && got < 3; i++) begin
            ntick();
            if (dv_a) begin
                check("bp_order", d_b, got + 1);
                got++;
            end
        end
        check("bp_count", got, 3);

        // Counter sticks at 3, then clear beats a simultaneous increment.
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        ntick();
        repeat (5) stim_q.push_back(65535);
        got = 0;
        for (int i = 0; i < 30 && got < 5; i++) begin
            ntick();
            if (dv_a && rdy) got++;
        end
        ntick();
        check("sat_sticky", cnt_a, 3);
        tick(); rdy = 1'b0;
        ntick();
        stim_q.push_back(65535);
        wait_dv(w);
        check("pre_clear_cnt", cnt_a, 3);
        tick(); rdy = 1'b1; clr = 1'b1;
        tick(); clr = 1'b0;
        ntick();
        check("clear_prio_a", cnt_a, 0);
        check("clear_prio_b", cnt_b, 0);

        // Reset with two results in flight.
        tick(); rdy = 1'b0;
        ntick();
        stim_q.push_back(11);
        stim_q.push_back(22);
        wait_dv(w);
        ntick();
        check("inflight", sb.size(), 2);
        tick(); rst = 1'b1;
        ntick();
        tick(); rst = 1'b0;
        ntick();
        check("mid_rst_valid", dv_a, 0);
        check("mid_rst_data", d_a, 0);
        check("mid_rst_flag", fl_a, 0);
        check("mid_rst_count", cnt_a, 0);
        check("mid_rst_ready", sr_a, 1);
        tick(); rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ntick();
            check("no_ghost", dv_a, 0);
        end

        // Randomized traffic with random stalls and clears.
        gap_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rdy = ($urandom_range(99) < 70);
            clr = ($urandom_range(99) < 3);
            ntick();
            if (stim_q.size() < 4 && $urandom_range(99) < 60) stim_q.push_back(rand_sum());
        end
        tick(); rdy = 1'b1; clr = 1'b0;
        for (int i = 0; i < 200 && (stim_q.size() > 0 || sb.size() > 0); i++) ntick();
        ntick();
        check("drain_sb", sb.size(), 0);
        check("drain_stim", stim_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
